// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, FSM encoding and the
// winning-line table used by the controller and the display bench.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } cell_e;

  localparam logic [1:0] S_TURN  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WIN   = 2'd2;
  localparam logic [1:0] S_DRAW  = 2'd3;

  localparam int NCELL = 9;
  localparam int NLINE = 8;

  // Rows 0-2, columns 3-5, diagonals 6-7
  localparam logic [0:7][0:2][3:0] WIN_LINES = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [8:0] line_mask(input int l);
    logic [8:0] m;
    m = '0;
    for (int k = 0; k < 3; k++) m[WIN_LINES[l][k]] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus saturating stable-high counter that
// emits a single press pulse per hold of the raw button.
module key_debounce
  import ttt_pkg::*;
#(
  parameter int DB_CNT = 250000,
  parameter int DB_W   = 18
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic press_o
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CNT);
  localparam logic [DB_W-1:0] CNT_ARM = DB_W'(DB_CNT - 1);

  logic [1:0]      sync_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d   = cnt_q + 1'b1;
      press_d = (cnt_q == CNT_ARM);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: debounced cell keys, turn FSM, board
// register and a registered win/draw checker feeding dot_display.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int DB_CNT = 250000,
  parameter int DB_W   = 18
) (
  input  logic        freq,
  input  logic        rst,
  input  logic [8:0]  key,
  input  logic        new_game,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [8:0]  win_line,
  output logic        illegal
);

  logic [9:0] raw, press;
  logic [8:0] kp;
  logic       ng;

  assign raw = {new_game, key};
  assign kp  = press[8:0];
  assign ng  = press[9];

  for (genvar g = 0; g < 10; g++) begin : g_db
    key_debounce #(
      .DB_CNT(DB_CNT),
      .DB_W  (DB_W)
    ) u_db (
      .clk_i  (freq),
      .rst_ni (rst),
      .raw_i  (raw[g]),
      .press_o(press[g])
    );
  end

  logic [1:0]       state_q, state_d;
  logic [8:0][1:0]  board_q, board_d;
  logic             turn_q, turn_d;
  logic [1:0]       winner_q, winner_d;
  logic [8:0]       wl_q, wl_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ill_q, ill_d;

  logic       multi;
  logic [3:0] kidx;
  logic       hit;
  logic [1:0] hit_code;
  logic [8:0] hit_mask;

  assign multi = |(kp & (kp - 9'd1));

  always_comb begin
    kidx = '0;
    for (int i = 0; i < NCELL; i++)
      if (kp[i]) kidx = 4'(i);
  end

  // Descending scan so the lowest winning line index is kept
  always_comb begin
    hit      = 1'b0;
    hit_code = EMPTY;
    hit_mask = '0;
    for (int l = NLINE - 1; l >= 0; l--) begin
      if (board_q[WIN_LINES[l][0]] != EMPTY &&
          board_q[WIN_LINES[l][0]] == board_q[WIN_LINES[l][1]] &&
          board_q[WIN_LINES[l][0]] == board_q[WIN_LINES[l][2]]) begin
        hit      = 1'b1;
        hit_code = board_q[WIN_LINES[l][0]];
        hit_mask = line_mask(l);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    wl_d     = wl_q;
    cnt_d    = cnt_q;
    ill_d    = 1'b0;
    if (ng) begin
      state_d  = S_TURN;
      board_d  = '0;
      turn_d   = 1'b0;
      winner_d = EMPTY;
      wl_d     = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_TURN: begin
          if (multi) begin
            ill_d = 1'b1;
          end else if (|kp) begin
            if (board_q[kidx] != EMPTY) begin
              ill_d = 1'b1;
            end else begin
              board_d[kidx] = turn_q ? P2 : P1;
              if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
              turn_d  = ~turn_q;
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (hit) begin
            winner_d = hit_code;
            wl_d     = hit_mask;
            state_d  = S_WIN;
          end else if (cnt_q == 4'd9) begin
            state_d = S_DRAW;
          end else begin
            state_d = S_TURN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge freq) begin
    if (!rst) begin
      state_q  <= S_TURN;
      board_q  <= '0;
      turn_q   <= 1'b0;
      winner_q <= EMPTY;
      wl_q     <= '0;
      cnt_q    <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      wl_q     <= wl_d;
      cnt_q    <= cnt_d;
      ill_q    <= ill_d;
    end
  end

  assign board     = board_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign win_line  = wl_q;
  assign illegal   = ill_q;
  assign game_over = (state_q == S_WIN) || (state_q == S_DRAW);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scenario bench for ttt_game_ctrl with a short debounce window;
// expected snapshots are queued at stimulus time and popped on output.
module tb_ttt_game_ctrl;

  typedef struct packed {
    logic [17:0] b;
    logic        t;
    logic [1:0]  w;
    logic        go;
    logic [8:0]  wl;
  } snap_t;

  logic        freq = 1'b0;
  logic        rst = 1'b0;
  logic        new_game = 1'b0;
  logic [8:0]  key = '0;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  winner;
  logic        game_over;
  logic [8:0]  win_line;
  logic        illegal;

  always #5 freq = ~freq;

  ttt_game_ctrl #(.DB_CNT(4), .DB_W(4)) dut (
    .freq     (freq),
    .rst      (rst),
    .key      (key),
    .new_game (new_game),
    .board    (board),
    .turn     (turn),
    .winner   (winner),
    .game_over(game_over),
    .win_line (win_line),
    .illegal  (illegal)
  );

  snap_t      sb[$];
  snap_t      e;
  int         checks = 0;
  int         passed = 0;
  int         ill_cnt = 0;
  logic [1:0] mb[9];
  logic       mt;

  always @(negedge freq)
    if (rst && illegal === 1'b1) ill_cnt++;

  function automatic snap_t obs();
    return '{board, turn, winner, game_over, win_line};
  endfunction

  function automatic snap_t mk(logic [1:0] w, logic go, logic [8:0] wl);
    snap_t s;
    s.b = '0;
    for (int i = 0; i < 9; i++) s.b[2*i +: 2] = mb[i];
    s.t  = mt;
    s.w  = w;
    s.go = go;
    s.wl = wl;
    return s;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge freq);
  endtask

  task automatic press(input logic [8:0] m);
    @(negedge freq);
    key = m;
    cyc(8);
    key = '0;
    cyc(6);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) mb[i] = 2'd0;
    mt = 1'b0;
  endtask

  task automatic press_ng();
    @(negedge freq);
    new_game = 1'b1;
    cyc(8);
    new_game = 1'b0;
    cyc(6);
    model_clear();
    sb.push_back(mk(2'd0, 1'b0, 9'd0));
  endtask

  task automatic move(input int c, input logic [1:0] w,
                      input logic go, input logic [8:0] wl);
    mb[c] = mt ? 2'd2 : 2'd1;
    mt = ~mt;
    sb.push_back(mk(w, go, wl));
    press(9'(1) << c);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(2);
    @(negedge freq);
    rst = 1'b1;
    model_clear();
    sb.push_back(mk(2'd0, 1'b0, 9'd0));
    cyc(1);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL reset: got %h want %h", obs(), e);
    else passed++;
    checks++;
    if (ill_cnt !== 0) $display("FAIL reset_illegal: got %0d want 0", ill_cnt);
    else passed++;
  endtask

  task automatic test_debounce();
    int n;
    @(negedge freq);
    for (int i = 0; i < 10; i++) begin
      key[4] = ~key[4];
      @(negedge freq);
    end
    mb[4] = 2'd1;
    mt = 1'b1;
    sb.push_back(mk(2'd0, 1'b0, 9'd0));
    key[4] = 1'b1;
    n = 0;
    while (board === '0 && n < 20) begin
      @(negedge freq);
      n++;
    end
    checks++;
    if (n !== 7) $display("FAIL debounce_latency: got %0d cycles want 7", n);
    else passed++;
    key = '0;
    cyc(6);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL debounce_move: got %h want %h", obs(), e);
    else passed++;
    checks++;
    if (ill_cnt !== 0) $display("FAIL debounce_illegal: got %0d want 0", ill_cnt);
    else passed++;
    press_ng();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL debounce_clear: got %h want %h", obs(), e);
    else passed++;
  endtask

  task automatic test_row_win();
    int cells[4] = '{0, 3, 1, 4};
    int i0;
    for (int i = 0; i < 4; i++) begin
      move(cells[i], 2'd0, 1'b0, 9'd0);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) $display("FAIL row_move%0d: got %h want %h", i, obs(), e);
      else passed++;
    end
    move(2, 2'd1, 1'b1, 9'b000000111);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL row_win: got %h want %h", obs(), e);
    else passed++;
    i0 = ill_cnt;
    sb.push_back(mk(2'd1, 1'b1, 9'b000000111));
    press(9'h100);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL row_frozen: got %h want %h", obs(), e);
    else passed++;
    checks++;
    if (ill_cnt !== i0) $display("FAIL row_frozen_illegal: got %0d want %0d", ill_cnt, i0);
    else passed++;
    press_ng();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL row_clear: got %h want %h", obs(), e);
    else passed++;
  endtask

  task automatic test_illegal();
    int i0;
    move(4, 2'd0, 1'b0, 9'd0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL ill_first: got %h want %h", obs(), e);
    else passed++;
    i0 = ill_cnt;
    sb.push_back(mk(2'd0, 1'b0, 9'd0));
    press(9'h010);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL ill_occupied: got %h want %h", obs(), e);
    else passed++;
    checks++;
    if (ill_cnt !== i0 + 1) $display("FAIL ill_occupied_pulse: got %0d want %0d", ill_cnt, i0 + 1);
    else passed++;
    sb.push_back(mk(2'd0, 1'b0, 9'd0));
    press(9'h003);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL ill_multi: got %h want %h", obs(), e);
    else passed++;
    checks++;
    if (ill_cnt !== i0 + 2) $display("FAIL ill_multi_pulse: got %0d want %0d", ill_cnt, i0 + 2);
    else passed++;
    press_ng();
    void'(sb.pop_front());
  endtask

  task automatic test_draw();
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    for (int i = 0; i < 8; i++) begin
      move(seq[i], 2'd0, 1'b0, 9'd0);
      void'(sb.pop_front());
    end
    move(seq[8], 2'd0, 1'b1, 9'd0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL draw: got %h want %h", obs(), e);
    else passed++;
    press_ng();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL draw_clear: got %h want %h", obs(), e);
    else passed++;
  endtask

  task automatic test_clear();
    int i0;
    move(0, 2'd0, 1'b0, 9'd0);
    void'(sb.pop_front());
    move(8, 2'd0, 1'b0, 9'd0);
    void'(sb.pop_front());
    move(4, 2'd0, 1'b0, 9'd0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL clear_moves: got %h want %h", obs(), e);
    else passed++;
    press_ng();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL clear_midgame: got %h want %h", obs(), e);
    else passed++;
    i0 = ill_cnt;
    sb.push_back(mk(2'd0, 1'b0, 9'd0));
    @(negedge freq);
    key = 9'h001;
    cyc(4);
    rst = 1'b0;
    key = '0;
    cyc(3);
    rst = 1'b1;
    cyc(12);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL clear_rst_debounce: got %h want %h", obs(), e);
    else passed++;
    checks++;
    if (ill_cnt !== i0) $display("FAIL clear_rst_illegal: got %0d want %0d", ill_cnt, i0);
    else passed++;
    move(2, 2'd0, 1'b0, 9'd0);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) $display("FAIL clear_after_rst: got %h want %h", obs(), e);
    else passed++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_debounce();
    test_row_win();
    test_illegal();
    test_draw();
    test_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
